// File: rtl/reg_group_seq.sv
// Command sequencer for the 3-entry register group.
// Turns LOAD/MOVE/SWAP/ADD commands into read/write cycles on the group.
module reg_group_seq #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [1:0]    cmd_rs,
    input  logic [1:0]    cmd_rd,
    input  logic [DW-1:0] cmd_imm,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          carry,
    output logic [1:0]    rg_raa,
    output logic [1:0]    rg_rwba,
    output logic          rg_we,
    output logic [DW-1:0] rg_i,
    input  logic [DW-1:0] rg_s,
    input  logic [DW-1:0] rg_d
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR1,
        WR2,
        FIN
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MOVE = 2'b01;
    localparam logic [1:0] OP_SWAP = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b11;

    state_t        state_q, state_d;
    logic [1:0]    op_q, rs_q, rd_q;
    logic [DW-1:0] imm_q, ts_q, td_q;
    logic          err_q, carry_q;
    logic          accept, illegal;
    logic [DW:0]   sum;

    assign accept  = (state_q == IDLE) && cmd_valid;
    assign illegal = (cmd_rd == 2'd3) ||
                     ((cmd_op != OP_LOAD) && (cmd_rs == 2'd3));
    assign sum     = {1'b0, ts_q} + {1'b0, td_q};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (illegal)               state_d = FIN;
                    else if (cmd_op == OP_LOAD) state_d = WR1;
                    else                        state_d = RD;
                end
            end
            RD:      state_d = WR1;
            WR1:     state_d = (op_q == OP_SWAP) ? WR2 : FIN;
            WR2:     state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            rs_q    <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            ts_q    <= '0;
            td_q    <= '0;
            err_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= cmd_op;
                rs_q  <= cmd_rs;
                rd_q  <= cmd_rd;
                imm_q <= cmd_imm;
                err_q <= illegal;
            end
            if (state_q == RD) begin
                ts_q <= rg_s;
                td_q <= rg_d;
            end
            // carry only moves on a real ADD write, never on a rejected one
            if (state_q == WR1 && op_q == OP_ADD)
                carry_q <= sum[DW];
        end
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        rg_raa    = 2'd0;
        rg_rwba   = 2'd0;
        rg_we     = 1'b1;
        rg_i      = '0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            RD: begin
                rg_raa  = rs_q;
                rg_rwba = rd_q;
            end
            WR1: begin
                rg_rwba = rd_q;
                rg_we   = 1'b0;
                unique case (op_q)
                    OP_LOAD: rg_i = imm_q;
                    OP_ADD:  rg_i = sum[DW-1:0];
                    default: rg_i = ts_q;
                endcase
            end
            WR2: begin
                rg_rwba = rs_q;
                rg_we   = 1'b0;
                rg_i    = td_q;
            end
            FIN: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    assign carry = carry_q;

endmodule

// File: tb/tb_reg_group_seq.sv
// Scoreboard bench for reg_group_seq with a behavioural register group.
// Commands push expectations; a monitor checks them on each done pulse.
module tb_reg_group_seq;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op, cmd_rs, cmd_rd;
    logic [DW-1:0] cmd_imm;
    logic          busy, done, err, carry;
    logic [1:0]    rg_raa, rg_rwba;
    logic          rg_we;
    logic [DW-1:0] rg_i, rg_s, rg_d;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string    name;
        logic     err;
        logic     carry;
        logic [7:0] a, b, c;
        int       lat;
        int       wes;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    reg_group_seq #(.DW(DW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rd(cmd_rd),
        .cmd_imm(cmd_imm),
        .busy(busy), .done(done), .err(err), .carry(carry),
        .rg_raa(rg_raa), .rg_rwba(rg_rwba), .rg_we(rg_we),
        .rg_i(rg_i), .rg_s(rg_s), .rg_d(rg_d)
    );

    // register group: write port active-low, commits on falling edge
    logic [7:0] gr [3] = '{default: 8'h00};
    always @(negedge clk)
        if (!rg_we && rg_rwba != 2'd3) gr[rg_rwba] <= rg_i;
    assign rg_s = (rg_raa  == 2'd3) ? 8'h00 : gr[rg_raa];
    assign rg_d = (rg_rwba == 2'd3) ? 8'h00 : gr[rg_rwba];

    function automatic void chk(string nm, int act, int expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endfunction

    int lat_cnt = 0;
    int we_cnt  = 0;

    always @(negedge clk) begin
        if (rst) begin
            lat_cnt = 0;
            we_cnt  = 0;
        end else begin
            if (!rg_we) we_cnt++;
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk({e.name, ".err"},   int'(err),   int'(e.err));
                    chk({e.name, ".carry"}, int'(carry), int'(e.carry));
                    chk({e.name, ".A"},     int'(gr[0]), int'(e.a));
                    chk({e.name, ".B"},     int'(gr[1]), int'(e.b));
                    chk({e.name, ".C"},     int'(gr[2]), int'(e.c));
                    chk({e.name, ".lat"},   lat_cnt,     e.lat);
                    chk({e.name, ".we_lo"}, we_cnt,      e.wes);
                end
                lat_cnt = 0;
                we_cnt  = 0;
            end else if (busy) begin
                lat_cnt++;
            end
        end
    end

    task automatic wait_ready();
        int t;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        if (t == 50) chk("ready_timeout", 0, 1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] rs,
                         input logic [1:0] rd, input logic [7:0] imm);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rs    = rs;
        cmd_rd    = rd;
        cmd_imm   = imm;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic expect_cmd(string nm, logic e_err, logic e_c,
                              logic [7:0] a, logic [7:0] b, logic [7:0] c,
                              int lat, int wes);
        exp_t e;
        e.name = nm; e.err = e_err; e.carry = e_c;
        e.a = a; e.b = b; e.c = c; e.lat = lat; e.wes = wes;
        q.push_back(e);
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 100; t++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        if (t == 100) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0;
        cmd_op = 2'd0; cmd_rs = 2'd0; cmd_rd = 2'd0; cmd_imm = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.we",    int'(rg_we),   1);
        chk("rst.busy",  int'(busy),    0);
        chk("rst.done",  int'(done),    0);
        chk("rst.carry", int'(carry),   0);
        chk("rst.raa",   int'(rg_raa),  0);
        chk("rst.rwba",  int'(rg_rwba), 0);
        chk("rst.i",     int'(rg_i),    0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst.ready", int'(cmd_ready), 1);

        expect_cmd("ldA", 0, 0, 8'h5A, 8'h00, 8'h00, 1, 1);
        issue(2'd0, 2'd0, 2'd0, 8'h5A);
        expect_cmd("ldB", 0, 0, 8'h5A, 8'hC3, 8'h00, 1, 1);
        issue(2'd0, 2'd0, 2'd1, 8'hC3);
        expect_cmd("swapAB", 0, 0, 8'hC3, 8'h5A, 8'h00, 3, 2);
        issue(2'd2, 2'd0, 2'd1, 8'h00);

        expect_cmd("ldA_F0", 0, 0, 8'hF0, 8'h5A, 8'h00, 1, 1);
        issue(2'd0, 2'd0, 2'd0, 8'hF0);
        expect_cmd("ldB_20", 0, 0, 8'hF0, 8'h20, 8'h00, 1, 1);
        issue(2'd0, 2'd0, 2'd1, 8'h20);
        expect_cmd("add1", 0, 1, 8'h10, 8'h20, 8'h00, 2, 1);
        issue(2'd3, 2'd1, 2'd0, 8'h00);
        expect_cmd("ldA_01", 0, 1, 8'h01, 8'h20, 8'h00, 1, 1);
        issue(2'd0, 2'd0, 2'd0, 8'h01);
        expect_cmd("ldB_02", 0, 1, 8'h01, 8'h02, 8'h00, 1, 1);
        issue(2'd0, 2'd0, 2'd1, 8'h02);
        expect_cmd("add2", 0, 0, 8'h03, 8'h02, 8'h00, 2, 1);
        issue(2'd3, 2'd1, 2'd0, 8'h00);

        expect_cmd("ldC_77", 0, 0, 8'h03, 8'h02, 8'h77, 1, 1);
        issue(2'd0, 2'd0, 2'd2, 8'h77);
        expect_cmd("moveCA", 0, 0, 8'h77, 8'h02, 8'h77, 2, 1);
        issue(2'd1, 2'd2, 2'd0, 8'h00);
        expect_cmd("move_rs3", 1, 0, 8'h77, 8'h02, 8'h77, 0, 0);
        issue(2'd1, 2'd3, 2'd0, 8'h00);
        expect_cmd("load_rd3", 1, 0, 8'h77, 8'h02, 8'h77, 0, 0);
        issue(2'd0, 2'd0, 2'd3, 8'hEE);
        drain();

        // reset lands inside SWAP WR1, before its first falling-edge write
        issue(2'd2, 2'd0, 2'd1, 8'h00);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst.we",   int'(rg_we), 1);
        chk("midrst.busy", int'(busy),  0);
        chk("midrst.done", int'(done),  0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst.ready", int'(cmd_ready), 1);
        chk("midrst.A",     int'(gr[0]),     8'h77);
        chk("midrst.B",     int'(gr[1]),     8'h02);

        expect_cmd("ldC_11", 0, 0, 8'h77, 8'h02, 8'h11, 1, 1);
        issue(2'd0, 2'd0, 2'd2, 8'h11);

        // valid held while busy with changing fields; only the SWAP C,C runs
        expect_cmd("swapCC", 0, 0, 8'h77, 8'h02, 8'h11, 3, 2);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op = 2'd2; cmd_rs = 2'd2; cmd_rd = 2'd2; cmd_imm = 8'h00;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            #1;
            cmd_op  = 2'(k);
            cmd_rs  = 2'd1;
            cmd_rd  = 2'd2;
            cmd_imm = 8'hA0 + 8'(k);
            @(posedge clk);
        end
        #1 cmd_valid = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("final.idle", int'(busy), 0);
        chk("final.C",    int'(gr[2]), 8'h11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
